mem_datos_responder: RTL and testbench
======================================

// Module: mem_datos_responder
// PURPOSE
//  Data-memory responder serving the pipeline's MEM stage; it is the slave end of the load/store interface.
//  Accepts one load/store request at a time over a valid/ready handshake and services it after WAIT_CYCLES.
//  Returns read data or a write acknowledge over a second valid/ready handshake.
//  Replaces the fixed-latency RAM core so the MEM stage can be exercised with variable memory latency.
// PARAMETERS
//  DATA_W       32    data word width (bits)
//  DEPTH        1024  words of storage; word index = req_addr[$clog2(DEPTH)+1:2]
//  WAIT_CYCLES  1     extra cycles between accept and response; 0 is legal
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       responder can accept; high only in IDLE
//  req_write   in   1       1 = store, 0 = load
//  req_addr    in   32      byte address; must be word-aligned
//  req_wdata   in   DATA_W  store data
//  req_be      in   4       byte enables, bit i -> bits [8i+7:8i]; present only with MEMDATOS_BE_EN
//  resp_valid  out  1       response present
//  resp_ready  in   1       requester accepts response
//  resp_rdata  out  DATA_W  load data; 0 for stores and errors
//  resp_err    out  1       misaligned (addr[1:0]!=0) or out of range (addr >= 4*DEPTH)
// BEHAVIOUR
//  - FSM states: IDLE, WAIT, RESP.
//    req_ready = (state==IDLE), combinational from state; req_ready is 1 immediately after reset.
//  - Accept edge: req_valid && req_ready. At this edge latch write, addr, wdata and be.
//    Go to WAIT if WAIT_CYCLES>0, else to RESP.
//  - WAIT: down-counter loaded with WAIT_CYCLES-1, width $clog2(WAIT_CYCLES+1). At 0, go to RESP.
//  - Service edge: the edge entering RESP (accept edge + WAIT_CYCLES).
//    Loads register memory data into resp_rdata. Stores commit to the array.
//    resp_err is registered at the same edge.
//  - Errored requests never write; resp_rdata=0 for them.
//  - RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_valid && resp_ready.
//    On that edge go to IDLE and clear resp_valid.
//  - No overlap: at most one transaction is in flight.
//    Minimum period is WAIT_CYCLES+2 cycles per transaction when resp_ready is held high.
//  - Request fields are ignored outside the accept edge; changes during WAIT/RESP have no effect.
//  - Read-after-write: a load accepted after a store's response returns the stored data.
//  - Reset (any time, including WAIT/RESP): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
//    A store not yet at its service edge is discarded. Array contents are not reset.
// CONFIGURATION
//  MEMDATOS_BE_EN defined:
//    req_be port exists. Stores update only the enabled byte lanes.
//    A store with be=4'b0000 completes with resp_err=0 and writes nothing.
//  MEMDATOS_BE_EN undefined:
//    req_be port is absent. Every store writes the full word. Loads always return the full word.
// STRUCTURE
//  - Package memdatos_pkg: state enum (IDLE/WAIT/RESP), DATA_W_DEF=32, DEPTH_DEF=1024, BE_W=4.
//  - Sub-module memdatos_ram: synchronous single-port array with registered read and per-byte write enable.
//    Under MEMDATOS_BE_EN it uses real byte enables; without it, be is tied to 4'hF.
//  - Top level holds the FSM, wait counter, address range/alignment check and response registers.
// TESTING
//  1. Reset released, idle: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
//  2. Store addr 0x10 data 0xDEADBEEF, then load 0x10 (WAIT_CYCLES=1, resp_ready=1):
//     resp_valid rises 2 cycles after each accept; the load returns 0xDEADBEEF with err=0.
//  3. Load addr 0x13, and load addr 0x1000 with DEPTH=1024: resp_err=1, resp_rdata=0.
//     Neither access modifies memory (confirm by reading back).
//  4. resp_ready held low 5 cycles in RESP: resp_valid, rdata and err are stable; req_ready=0 throughout.
//     Completion on the first cycle with resp_ready=1.
//  5. Assert rst_n low during WAIT of a store to 0x20 (prior content 0x1):
//     outputs clear asynchronously; a later load of 0x20 returns 0x1.
//  6. MEMDATOS_BE_EN: word 0x11223344 at 0x8, store 0xAABBCCDD with be=4'b0101 -> load returns 0x11BB33DD.
//     Repeat with WAIT_CYCLES=0: response 1 cycle after accept.

Source files
------------

// File: rtl/memdatos_pkg.sv
// memdatos_pkg: shared types and defaults for the data-memory responder.
//   state_t    : responder FSM states (IDLE / WAIT / RESP)
//   DATA_W_DEF : default data width, DEPTH_DEF : default word count, BE_W : byte lanes per word
package memdatos_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 1024;
    localparam int BE_W       = 4;
endpackage

// File: rtl/memdatos_ram.sv
// memdatos_ram: single-port word array with per-byte write enable and registered read.
//   i_clk, i_rst_n : clock, async active-low reset (clears only the read register)
//   i_en           : service strobe; write and read happen only on this edge
//   i_we / i_re    : commit store lanes / capture the addressed word (else read register clears to 0)
//   i_addr         : word index, i_wdata : store data, i_be : byte-lane enables
//   o_rdata        : registered read data, held between service strobes
module memdatos_ram
    import memdatos_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array contents survive reset, so the storage has no reset branch.
    always_ff @(posedge i_clk) begin
        if (i_en && i_we)
            for (int i = 0; i < BE_W; i++)
                if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end

    // Stores and errored accesses report zero data, so the register is cleared rather than loaded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rdata <= '0;
        else if (i_en) r_rdata <= i_re ? r_mem[i_addr] : '0;
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_datos_responder.sv
// mem_datos_responder: load/store slave for the MEM stage with WAIT_CYCLES of service latency.
//   i_clk, i_rst_n                       : clock, async active-low reset
//   i_req_valid / o_req_ready            : request handshake (ready only in IDLE)
//   i_req_write, i_req_addr, i_req_wdata : store flag, byte address, store data
//   i_req_be                             : byte enables, present only when MEMDATOS_BE_EN is defined
//   o_resp_valid / i_resp_ready          : response handshake
//   o_resp_rdata, o_resp_err             : load data (0 for stores/errors), misaligned or out-of-range flag
module mem_datos_responder
    import memdatos_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [31:0]       i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
`ifdef MEMDATOS_BE_EN
    input  logic [BE_W-1:0]   i_req_be,
`endif
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] o_resp_rdata,
    output logic              o_resp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_write;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_valid;
    logic              r_err;
`ifdef MEMDATOS_BE_EN
    logic [BE_W-1:0]   r_be;
`endif

    logic              w_idle;
    logic              w_svc;
    logic              w_write;
    logic [31:0]       w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [BE_W-1:0]   w_be;
    logic              w_err;

    // With zero wait the accept edge is also the service edge, so the
    // request fields are taken straight from the inputs while in IDLE.
    assign w_idle  = (r_state == IDLE);
    assign w_svc   = (w_idle && i_req_valid && WAIT_CYCLES == 0) || (r_state == WAIT && r_cnt == '0);
    assign w_write = w_idle ? i_req_write : r_write;
    assign w_addr  = w_idle ? i_req_addr  : r_addr;
    assign w_wdata = w_idle ? i_req_wdata : r_wdata;
`ifdef MEMDATOS_BE_EN
    assign w_be    = w_idle ? i_req_be : r_be;
`else
    assign w_be    = '1;
`endif
    assign w_err   = (w_addr[1:0] != 2'b00) || (w_addr >= 32'(BE_W * DEPTH));

    assign o_req_ready  = w_idle;
    assign o_resp_valid = r_valid;
    assign o_resp_err   = r_err;

    memdatos_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_svc),
        .i_we    (w_write && !w_err),
        .i_re    (!w_write && !w_err),
        .i_addr  (w_addr[AW+1:2]),
        .i_wdata (w_wdata),
        .i_be    (w_be),
        .o_rdata (o_resp_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
`ifdef MEMDATOS_BE_EN
            r_be    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (i_req_valid) begin
                    r_write <= i_req_write;
                    r_addr  <= i_req_addr;
                    r_wdata <= i_req_wdata;
`ifdef MEMDATOS_BE_EN
                    r_be    <= i_req_be;
`endif
                    r_cnt   <= CW'(WAIT_CYCLES - 1);
                    r_state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
                WAIT: if (r_cnt == '0) r_state <= RESP;
                      else r_cnt <= r_cnt - 1'b1;
                RESP: if (i_resp_ready) begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
            if (w_svc) begin
                r_valid <= 1'b1;
                r_err   <= w_err;
            end
        end
    end
endmodule

// File: tb/tb_mem_datos_responder.sv
// tb_mem_datos_responder: directed bench for three responder instances with WAIT_CYCLES of 1, 0 and 3.
module tb_mem_datos_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
`ifdef MEMDATOS_BE_EN
    logic [3:0]  req_be     [3];
`endif
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_datos_responder #(.DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : 3)) u_dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_req_valid  (req_valid[g]),
            .o_req_ready  (req_ready[g]),
            .i_req_write  (req_write[g]),
            .i_req_addr   (req_addr[g]),
            .i_req_wdata  (req_wdata[g]),
`ifdef MEMDATOS_BE_EN
            .i_req_be     (req_be[g]),
`endif
            .o_resp_valid (resp_valid[g]),
            .i_resp_ready (resp_ready[g]),
            .o_resp_rdata (resp_rdata[g]),
            .o_resp_err   (resp_err[g])
        );
    end

    // One full transaction with resp_ready high; lat counts negedges from the accept edge to resp_valid.
    task automatic txn(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
`ifdef MEMDATOS_BE_EN
        req_be[d]    = be;
`else
        if (be == 4'hx) req_wdata[d] = wd;
`endif
        resp_ready[d] = 1'b1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_wdata[d] = ~wd;
        req_addr[d]  = a ^ 32'h4;
        lat = 1;
        while (!resp_valid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata[d];
        er = resp_err[d];
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
            resp_ready[d] = 1'b0;
`ifdef MEMDATOS_BE_EN
            req_be[d] = 4'hF;
`endif
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++; if (req_ready[d] !== 1'b1) begin errs++; $display("FAIL rst_req_ready[%0d]: got %b exp 1", d, req_ready[d]); end
            checks++; if (resp_valid[d] !== 1'b0) begin errs++; $display("FAIL rst_resp_valid[%0d]: got %b exp 0", d, resp_valid[d]); end
            checks++; if (resp_rdata[d] !== 32'h0) begin errs++; $display("FAIL rst_rdata[%0d]: got %h exp 0", d, resp_rdata[d]); end
            checks++; if (resp_err[d] !== 1'b0) begin errs++; $display("FAIL rst_err[%0d]: got %b exp 0", d, resp_err[d]); end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        checks++; if (lat !== 2) begin errs++; $display("FAIL st_lat: got %0d exp 2", lat); end
        checks++; if ({er, rd} !== {1'b0, 32'h0}) begin errs++; $display("FAIL st_resp: got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
        checks++; if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin errs++; $display("FAIL st_done: got ready=%b valid=%b exp 1 0", req_ready[0], resp_valid[0]); end
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        checks++; if (lat !== 2) begin errs++; $display("FAIL ld_lat: got %0d exp 2", lat); end
        checks++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin errs++; $display("FAIL ld_resp: got err=%b rdata=%h exp err=0 rdata=deadbeef", er, rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, 32'h0, 32'hCAFE0000, 4'hF, rd, er, lat);
        txn(0, 1'b1, 32'h1000, 32'h0000FFFF, 4'hF, rd, er, lat);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errs++; $display("FAIL st_range: got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        txn(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
        checks++; if ({er, rd} !== {1'b0, 32'hCAFE0000}) begin errs++; $display("FAIL rb_word0: got err=%b rdata=%h exp err=0 rdata=cafe0000", er, rd); end
        txn(0, 1'b1, 32'h13, 32'h12345678, 4'hF, rd, er, lat);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errs++; $display("FAIL st_misalign: got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        txn(0, 1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errs++; $display("FAIL ld_misalign: got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        txn(0, 1'b0, 32'h1000, 32'h0, 4'hF, rd, er, lat);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errs++; $display("FAIL ld_range: got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
        txn(0, 1'b0, 32'h0FFC, 32'h0, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b0) begin errs++; $display("FAIL ld_last: got err=%b exp 0", er); end
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        checks++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin errs++; $display("FAIL rb_word10: got err=%b rdata=%h exp err=0 rdata=deadbeef", er, rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10; resp_ready[0] = 1'b0;
        @(negedge clk);
        req_valid[0] = 1'b0;
        lat = 1;
        while (!resp_valid[0] && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat !== 2) begin errs++; $display("FAIL bp_lat: got %0d exp 2", lat); end
        for (int k = 0; k < 5; k++) begin
            req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h10; req_wdata[0] = 32'h0;
            checks++;
            if ({resp_valid[0], req_ready[0], resp_err[0], resp_rdata[0]} !== {1'b1, 1'b0, 1'b0, 32'hDEADBEEF}) begin
                errs++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b err=%b rdata=%h exp 1 0 0 deadbeef",
                         k, resp_valid[0], req_ready[0], resp_err[0], resp_rdata[0]);
            end
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        resp_ready[0] = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin errs++; $display("FAIL bp_release: got valid=%b ready=%b exp 0 1", resp_valid[0], req_ready[0]); end
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL bp_ignored: got %h exp deadbeef", rd); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, 32'h20, 32'h1, 4'hF, rd, er, lat);
        txn(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h99;
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++; if (req_ready[0] !== 1'b0 || resp_rdata[0] !== 32'h1) begin errs++; $display("FAIL mf_wait: got ready=%b rdata=%h exp 0 00000001", req_ready[0], resp_rdata[0]); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready[0], resp_valid[0], resp_err[0], resp_rdata[0]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errs++;
            $display("FAIL mf_async: got ready=%b valid=%b err=%b rdata=%h exp 1 0 0 0", req_ready[0], resp_valid[0], resp_err[0], resp_rdata[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        txn(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        checks++; if ({er, rd} !== {1'b0, 32'h1}) begin errs++; $display("FAIL mf_discard: got err=%b rdata=%h exp err=0 rdata=00000001", er, rd); end
    endtask

    task automatic test_wait_zero();
        logic [31:0] rd; logic er; int lat;
        txn(1, 1'b1, 32'h8, 32'h11223344, 4'hF, rd, er, lat);
        checks++; if (lat !== 1) begin errs++; $display("FAIL w0_st_lat: got %0d exp 1", lat); end
`ifdef MEMDATOS_BE_EN
        txn(1, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        checks++; if (er !== 1'b0) begin errs++; $display("FAIL w0_be_err: got %b exp 0", er); end
        txn(1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
        checks++; if ({lat, rd} !== {32'd1, 32'h11BB33DD}) begin errs++; $display("FAIL w0_be_ld: got lat=%0d rdata=%h exp 1 11bb33dd", lat, rd); end
        txn(1, 1'b1, 32'h8, 32'h55555555, 4'b0000, rd, er, lat);
        checks++; if (er !== 1'b0) begin errs++; $display("FAIL w0_be0_err: got %b exp 0", er); end
        txn(1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'h11BB33DD) begin errs++; $display("FAIL w0_be0_ld: got %h exp 11bb33dd", rd); end
`else
        txn(1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
        checks++; if ({lat, rd} !== {32'd1, 32'h11223344}) begin errs++; $display("FAIL w0_ld: got lat=%0d rdata=%h exp 1 11223344", lat, rd); end
        txn(1, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        txn(1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'hAABBCCDD) begin errs++; $display("FAIL w0_full: got %h exp aabbccdd", rd); end
`endif
        txn(1, 1'b0, 32'hFFF, 32'h0, 4'hF, rd, er, lat);
        checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errs++; $display("FAIL w0_err: got err=%b rdata=%h exp 1 0", er, rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat;
        txn(1, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, rd, er, lat);
        checks++; if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin errs++; $display("FAIL b2b_idle: got ready=%b valid=%b exp 1 0", req_ready[1], resp_valid[1]); end
        txn(1, 1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'h0BADF00D) begin errs++; $display("FAIL b2b_ld: got %h exp 0badf00d", rd); end
    endtask

    task automatic test_wait_three();
        logic [31:0] rd; logic er; int lat;
        txn(2, 1'b1, 32'h44, 32'h76543210, 4'hF, rd, er, lat);
        checks++; if (lat !== 4) begin errs++; $display("FAIL w3_st_lat: got %0d exp 4", lat); end
        txn(2, 1'b0, 32'h44, 32'h0, 4'hF, rd, er, lat);
        checks++; if ({lat, er, rd} !== {32'd4, 1'b0, 32'h76543210}) begin errs++; $display("FAIL w3_ld: got lat=%0d err=%b rdata=%h exp 4 0 76543210", lat, er, rd); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_backpressure();
        test_reset_midflight();
        test_wait_zero();
        test_back_to_back();
        test_wait_three();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
